// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states and the
// captured-request record used by the pending slots and the issue mux.
package mem_arbiter_pkg;

   localparam int unsigned ARB_XLEN = 32;
   localparam int unsigned ARB_ALEN = 32;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_I,
      BUSY_D
   } arbiter_state_type;

   typedef struct packed {
      logic                valid;
      logic                fence;
      logic                instr;
      logic [ARB_ALEN-1:0] addr;
      logic [ARB_XLEN-1:0] wdata;
      logic [3:0]          wstrb;
   } arb_req_type;

endpackage

// File: rtl/mem_arbiter_slot.sv
// One-entry request capture register; load wins over clear.
module arb_slot
   import mem_arbiter_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic        clear,
   input  arb_req_type d,
   output arb_req_type q
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end else if (clear) begin
         q.valid <= 1'b0;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and data requesters: one buffered
// request per side, data priority, zero-latency issue, combinational responses.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned XLEN = ARB_XLEN,
   parameter int unsigned ALEN = ARB_ALEN
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            i_valid,
   input  logic [ALEN-1:0] i_addr,
   output logic            i_ready,
   output logic [XLEN-1:0] i_rdata,
   input  logic            d_valid,
   input  logic            d_fence,
   input  logic [ALEN-1:0] d_addr,
   input  logic [XLEN-1:0] d_wdata,
   input  logic [3:0]      d_wstrb,
   output logic            d_ready,
   output logic [XLEN-1:0] d_rdata,
   output logic            m_valid,
   output logic            m_fence,
   output logic            m_instr,
   output logic [ALEN-1:0] m_addr,
   output logic [XLEN-1:0] m_wdata,
   output logic [3:0]      m_wstrb,
   input  logic            m_ready,
   input  logic [XLEN-1:0] m_rdata,
   output logic            err
);

   if (XLEN != ARB_XLEN || ALEN != ARB_ALEN) begin : g_width_check
      $error("mem_arbiter: XLEN/ALEN must match mem_arbiter_pkg widths");
   end

   arbiter_state_type state, state_next;
   arb_req_type       pend_i, pend_d, new_i, new_d, win;
   logic              active, err_q;
   logic              i_done, d_done, can_issue, issue;
   logic              i_viol, d_viol, i_acc, d_acc;
   logic              sel_pd, sel_nd, sel_pi, sel_ni;
   logic              load_i, clear_i, load_d, clear_d;

   // Outputs stay quiet for the first cycle after reset; requests are ignored then too.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         active <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_next;
         active <= 1'b1;
         if (i_viol || d_viol) err_q <= 1'b1;
      end
   end

   arb_slot u_slot_i (
      .clock (clock),
      .reset (reset),
      .load  (load_i),
      .clear (clear_i),
      .d     (new_i),
      .q     (pend_i)
   );

   arb_slot u_slot_d (
      .clock (clock),
      .reset (reset),
      .load  (load_d),
      .clear (clear_d),
      .d     (new_d),
      .q     (pend_d)
   );

   always_comb begin
      new_i       = '0;
      new_i.valid = 1'b1;
      new_i.instr = 1'b1;
      new_i.addr  = i_addr;

      new_d       = '0;
      new_d.valid = 1'b1;
      new_d.fence = d_fence;
      new_d.addr  = d_addr;
      new_d.wdata = d_wdata;
      new_d.wstrb = d_wstrb;

      i_done    = active && (state == BUSY_I) && m_ready;
      d_done    = active && (state == BUSY_D) && m_ready;
      can_issue = active && ((state == IDLE) || i_done || d_done);

      // A request on the cycle its own response returns is a fresh candidate.
      i_viol = active && i_valid && (pend_i.valid || ((state == BUSY_I) && !m_ready));
      d_viol = active && d_valid && (pend_d.valid || ((state == BUSY_D) && !m_ready));
      i_acc  = active && i_valid && !i_viol;
      d_acc  = active && d_valid && !d_viol;

      sel_pd = pend_d.valid;
      sel_nd = !sel_pd && d_acc;
      sel_pi = !sel_pd && !sel_nd && pend_i.valid;
      sel_ni = !sel_pd && !sel_nd && !sel_pi && i_acc;

      win = '0;
      if (sel_pd)      win = pend_d;
      else if (sel_nd) win = new_d;
      else if (sel_pi) win = pend_i;
      else if (sel_ni) win = new_i;

      issue = can_issue && win.valid;

      load_d  = d_acc && !(issue && sel_nd);
      clear_d = issue && sel_pd;
      load_i  = i_acc && !(issue && sel_ni);
      clear_i = issue && sel_pi;

      state_next = state;
      if (issue)                 state_next = win.instr ? BUSY_I : BUSY_D;
      else if (i_done || d_done) state_next = IDLE;

      m_valid = issue;
      m_fence = issue && win.fence;
      m_instr = issue && win.instr;
      m_addr  = issue ? win.addr  : '0;
      m_wdata = issue ? win.wdata : '0;
      m_wstrb = issue ? win.wstrb : '0;

      i_ready = i_done;
      i_rdata = i_done ? m_rdata : '0;
      d_ready = d_done;
      d_rdata = d_done ? m_rdata : '0;
      err     = err_q;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

   logic        clock;
   logic        reset;
   logic        i_valid;
   logic [31:0] i_addr;
   logic        i_ready;
   logic [31:0] i_rdata;
   logic        d_valid;
   logic        d_fence;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wstrb;
   logic        d_ready;
   logic [31:0] d_rdata;
   logic        m_valid;
   logic        m_fence;
   logic        m_instr;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_ready;
   logic [31:0] m_rdata;
   logic        err;

   int unsigned checks = 0;
   int unsigned errors = 0;

   mem_arbiter #(.XLEN(32), .ALEN(32)) dut (
      .clock   (clock),
      .reset   (reset),
      .i_valid (i_valid),
      .i_addr  (i_addr),
      .i_ready (i_ready),
      .i_rdata (i_rdata),
      .d_valid (d_valid),
      .d_fence (d_fence),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_wstrb (d_wstrb),
      .d_ready (d_ready),
      .d_rdata (d_rdata),
      .m_valid (m_valid),
      .m_fence (m_fence),
      .m_instr (m_instr),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_wstrb (m_wstrb),
      .m_ready (m_ready),
      .m_rdata (m_rdata),
      .err     (err)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      i_valid = 1'b0;
      i_addr  = '0;
      d_valid = 1'b0;
      d_fence = 1'b0;
      d_addr  = '0;
      d_wdata = '0;
      d_wstrb = '0;
      m_ready = 1'b0;
      m_rdata = '0;
   endtask

   // Drive 1 time unit after the rising edge, sample at the falling edge.
   task automatic tick();
      @(posedge clock);
      #1;
      idle_inputs();
   endtask

   task automatic settle();
      #4;
   endtask

   task automatic check_quiet(input string tag);
      check_val({tag, "_m_valid"}, 64'(m_valid), 64'd0);
      check_val({tag, "_i_ready"}, 64'(i_ready), 64'd0);
      check_val({tag, "_d_ready"}, 64'(d_ready), 64'd0);
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;

      // Reset: requests and responses are gated off.
      #2;
      i_valid = 1'b1; i_addr = 32'h100; d_valid = 1'b1; m_ready = 1'b1;
      #1;
      check_quiet("rst");
      check_val("rst_err", 64'(err), 64'd0);
      check_val("rst_m_addr", 64'(m_addr), 64'd0);
      @(posedge clock); #1;
      idle_inputs();
      reset = 1'b0;
      // First cycle after reset: outputs stay zero, requests ignored.
      i_valid = 1'b1; i_addr = 32'h1F0;
      settle();
      check_quiet("post_rst");
      tick();
      settle();
      check_quiet("post_rst_next");

      // Lone fetch, response after 3 cycles.
      tick();
      i_valid = 1'b1; i_addr = 32'h100;
      settle();
      check_val("lone_m_valid", 64'(m_valid), 64'd1);
      check_val("lone_m_instr", 64'(m_instr), 64'd1);
      check_val("lone_m_addr", 64'(m_addr), 64'h100);
      check_val("lone_m_wstrb", 64'(m_wstrb), 64'd0);
      tick();
      settle();
      check_val("lone_wait1_m_valid", 64'(m_valid), 64'd0);
      tick();
      settle();
      check_val("lone_wait2_i_ready", 64'(i_ready), 64'd0);
      tick();
      m_ready = 1'b1; m_rdata = 32'h0000_0013;
      settle();
      check_val("lone_i_ready", 64'(i_ready), 64'd1);
      check_val("lone_i_rdata", 64'(i_rdata), 64'h13);
      check_val("lone_d_ready", 64'(d_ready), 64'd0);
      check_val("lone_m_valid_resp", 64'(m_valid), 64'd0);
      tick();
      // Stale response in IDLE is ignored.
      m_ready = 1'b1; m_rdata = 32'hFFFF_FFFF;
      settle();
      check_quiet("idle_stale");

      // Simultaneous fetch and data: data first.
      tick();
      i_valid = 1'b1; i_addr = 32'h200;
      d_valid = 1'b1; d_addr = 32'h8000; d_wstrb = 4'hF; d_wdata = 32'hDEAD_BEEF;
      settle();
      check_val("sim_m_valid", 64'(m_valid), 64'd1);
      check_val("sim_m_instr", 64'(m_instr), 64'd0);
      check_val("sim_m_addr", 64'(m_addr), 64'h8000);
      check_val("sim_m_wdata", 64'(m_wdata), 64'hDEAD_BEEF);
      check_val("sim_m_wstrb", 64'(m_wstrb), 64'hF);
      tick();
      settle();
      check_val("sim_wait_m_valid", 64'(m_valid), 64'd0);
      tick();
      m_ready = 1'b1; m_rdata = 32'h55;
      settle();
      check_val("sim_d_ready", 64'(d_ready), 64'd1);
      check_val("sim_d_rdata", 64'(d_rdata), 64'h55);
      check_val("sim_i_ready_early", 64'(i_ready), 64'd0);
      check_val("sim_fetch_m_valid", 64'(m_valid), 64'd1);
      check_val("sim_fetch_m_instr", 64'(m_instr), 64'd1);
      check_val("sim_fetch_m_addr", 64'(m_addr), 64'h200);
      tick();
      m_ready = 1'b1; m_rdata = 32'h77;
      settle();
      check_val("sim_i_ready", 64'(i_ready), 64'd1);
      check_val("sim_i_rdata", 64'(i_rdata), 64'h77);
      check_val("sim_d_ready_late", 64'(d_ready), 64'd0);
      check_val("sim_end_m_valid", 64'(m_valid), 64'd0);

      // Data captured while a fetch is outstanding.
      tick();
      i_valid = 1'b1; i_addr = 32'h400;
      settle();
      check_val("cap_fetch_m_valid", 64'(m_valid), 64'd1);
      tick();
      tick();
      d_valid = 1'b1; d_addr = 32'h8004; d_wstrb = 4'h0; d_fence = 1'b1;
      settle();
      check_val("cap_hold_m_valid", 64'(m_valid), 64'd0);
      tick();
      m_ready = 1'b1; m_rdata = 32'h99;
      settle();
      check_val("cap_i_ready", 64'(i_ready), 64'd1);
      check_val("cap_i_rdata", 64'(i_rdata), 64'h99);
      check_val("cap_d_m_valid", 64'(m_valid), 64'd1);
      check_val("cap_d_m_instr", 64'(m_instr), 64'd0);
      check_val("cap_d_m_addr", 64'(m_addr), 64'h8004);
      check_val("cap_d_m_wstrb", 64'(m_wstrb), 64'd0);
      check_val("cap_d_m_fence", 64'(m_fence), 64'd1);

      // Response/request overlap on the data side is legal.
      tick();
      m_ready = 1'b1; m_rdata = 32'hAB;
      d_valid = 1'b1; d_addr = 32'h8008; d_wstrb = 4'h3; d_wdata = 32'h1234;
      settle();
      check_val("ovl_d_ready", 64'(d_ready), 64'd1);
      check_val("ovl_d_rdata", 64'(d_rdata), 64'hAB);
      check_val("ovl_m_valid", 64'(m_valid), 64'd1);
      check_val("ovl_m_addr", 64'(m_addr), 64'h8008);
      check_val("ovl_m_wstrb", 64'(m_wstrb), 64'h3);
      check_val("ovl_m_fence", 64'(m_fence), 64'd0);
      tick();
      m_ready = 1'b1; m_rdata = 32'hCD;
      settle();
      check_val("ovl2_d_rdata", 64'(d_rdata), 64'hCD);
      check_val("ovl2_m_valid", 64'(m_valid), 64'd0);
      check_val("ovl_err", 64'(err), 64'd0);

      // Violation: second fetch while the first is outstanding.
      tick();
      i_valid = 1'b1; i_addr = 32'h100;
      settle();
      check_val("vio_first_m_addr", 64'(m_addr), 64'h100);
      tick();
      i_valid = 1'b1; i_addr = 32'h300;
      settle();
      check_val("vio_m_valid", 64'(m_valid), 64'd0);
      tick();
      settle();
      check_val("vio_err", 64'(err), 64'd1);
      tick();
      m_ready = 1'b1; m_rdata = 32'h11;
      settle();
      check_val("vio_i_ready", 64'(i_ready), 64'd1);
      check_val("vio_i_rdata", 64'(i_rdata), 64'h11);
      check_val("vio_no_reissue", 64'(m_valid), 64'd0);
      tick();
      settle();
      check_val("vio_idle_m_valid", 64'(m_valid), 64'd0);
      tick();
      settle();
      check_val("vio_err_sticky", 64'(err), 64'd1);

      // Reset while BUSY_D with a fetch pending.
      tick();
      d_valid = 1'b1; d_addr = 32'h9000; d_wstrb = 4'h1;
      settle();
      check_val("rmo_m_addr", 64'(m_addr), 64'h9000);
      tick();
      i_valid = 1'b1; i_addr = 32'h500;
      settle();
      check_val("rmo_hold_m_valid", 64'(m_valid), 64'd0);
      tick();
      m_ready = 1'b1; m_rdata = 32'hEE;
      #2;
      reset = 1'b1;
      #1;
      check_quiet("rmo_rst");
      check_val("rmo_rst_err", 64'(err), 64'd0);
      check_val("rmo_rst_d_rdata", 64'(d_rdata), 64'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      m_ready = 1'b1; m_rdata = 32'hEE;
      settle();
      check_quiet("rmo_stale0");
      tick();
      m_ready = 1'b1; m_rdata = 32'hEE;
      settle();
      check_quiet("rmo_stale1");
      tick();
      i_valid = 1'b1; i_addr = 32'h600;
      settle();
      check_val("rmo_idle_m_valid", 64'(m_valid), 64'd1);
      check_val("rmo_idle_m_addr", 64'(m_addr), 64'h600);
      check_val("rmo_err_cleared", 64'(err), 64'd0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
